// File: rtl/mem_bus_arbiter_if.sv
// Bundle of every requester-side and memory-side bus signal around the
// two-requester memory bus arbiter. The arbiter takes the master view; the
// requesters plus the memory (or a bench standing in for them) take the slave
// view.
interface mem_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  // requester 0 (cache miss-fill path)
  logic          cyc0_i;
  logic          we0_i;
  logic [AW-1:0] adr0_i;
  logic [DW-1:0] dat0_i;
  logic [DW-1:0] dat0_o;
  logic          ack0_o;
  logic          err0_o;

  // requester 1 (MSHR write-back path)
  logic          cyc1_i;
  logic          we1_i;
  logic [AW-1:0] adr1_i;
  logic [DW-1:0] dat1_i;
  logic [DW-1:0] dat1_o;
  logic          ack1_o;
  logic          err1_o;

  // shared memory-side bus
  logic          cyc_m2s;
  logic          we_m2s;
  logic [AW-1:0] adr_m2s;
  logic [DW-1:0] dat_m2s;
  logic [DW-1:0] dat_mem_i;
  logic          ack_mem_i;

  modport master (
    input  cyc0_i, we0_i, adr0_i, dat0_i,
    input  cyc1_i, we1_i, adr1_i, dat1_i,
    input  dat_mem_i, ack_mem_i,
    output dat0_o, ack0_o, err0_o,
    output dat1_o, ack1_o, err1_o,
    output cyc_m2s, we_m2s, adr_m2s, dat_m2s
  );

  modport slave (
    output cyc0_i, we0_i, adr0_i, dat0_i,
    output cyc1_i, we1_i, adr1_i, dat1_i,
    output dat_mem_i, ack_mem_i,
    input  dat0_o, ack0_o, err0_o,
    input  dat1_o, ack1_o, err1_o,
    input  cyc_m2s, we_m2s, adr_m2s, dat_m2s
  );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for the single memory-side bus.
// Requester 0 is the cache miss-fill path, requester 1 the MSHR write-back
// path. A grant holds the bus until ack, abort (requester drops cyc) or
// timeout; a timeout is reported to the owner as a bus error. Every grant
// returns through IDLE, so there is always one idle cycle between grants.
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  mem_bus_arbiter_if.master   bus,
  output logic [1:0]          state_test
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  // Counter value seen in the last granted cycle before an error is raised.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t        state;
  state_t        next_state;
  logic          last;
  logic [7:0]    cnt;
  logic          grant_start;

  logic          cyc_sel;
  logic          we_sel;
  logic [AW-1:0] adr_sel;
  logic [DW-1:0] dat_sel;
  logic          ack0;
  logic          ack1;
  logic          err0;
  logic          err1;
  logic [DW-1:0] rdat0;
  logic [DW-1:0] rdat1;

  // A new grant begins whenever we leave a non-granted state for a grant;
  // the unused encoding behaves exactly like IDLE.
  assign grant_start = (next_state != IDLE) && (state != GNT0) && (state != GNT1);

  // State register; reset drops any transaction in flight immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Round-robin pointer and timeout counter: both are reloaded on grant
  // entry, the counter then advances once per granted cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= 1'b1;
      cnt  <= 8'd0;
    end else if (grant_start) begin
      last <= (next_state == GNT1);
      cnt  <= 8'd0;
    end else if ((state == GNT0) || (state == GNT1)) begin
      cnt  <= cnt + 8'd1;
    end
  end

  // Next-state arbitration plus bus muxing and requester responses.
  always_comb begin
    next_state = state;
    cyc_sel    = 1'b0;
    we_sel     = 1'b0;
    adr_sel    = '0;
    dat_sel    = '0;
    ack0       = 1'b0;
    ack1       = 1'b0;
    err0       = 1'b0;
    err1       = 1'b0;
    rdat0      = '0;
    rdat1      = '0;
    case (state)
      GNT0: begin
        cyc_sel = bus.cyc0_i;
        we_sel  = bus.we0_i;
        adr_sel = bus.adr0_i;
        dat_sel = bus.dat0_i;
        if (!bus.cyc0_i) begin
          next_state = IDLE;
        end else if (bus.ack_mem_i) begin
          ack0       = 1'b1;
          rdat0      = bus.dat_mem_i;
          next_state = IDLE;
        end else if (cnt == TO_LAST) begin
          err0       = 1'b1;
          next_state = IDLE;
        end
      end
      GNT1: begin
        cyc_sel = bus.cyc1_i;
        we_sel  = bus.we1_i;
        adr_sel = bus.adr1_i;
        dat_sel = bus.dat1_i;
        if (!bus.cyc1_i) begin
          next_state = IDLE;
        end else if (bus.ack_mem_i) begin
          ack1       = 1'b1;
          rdat1      = bus.dat_mem_i;
          next_state = IDLE;
        end else if (cnt == TO_LAST) begin
          err1       = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
        if (bus.cyc0_i && bus.cyc1_i) begin
          next_state = last ? GNT0 : GNT1;
        end else if (bus.cyc0_i) begin
          next_state = GNT0;
        end else if (bus.cyc1_i) begin
          next_state = GNT1;
        end
      end
    endcase
  end

  assign bus.cyc_m2s = cyc_sel;
  assign bus.we_m2s  = we_sel;
  assign bus.adr_m2s = adr_sel;
  assign bus.dat_m2s = dat_sel;
  assign bus.ack0_o  = ack0;
  assign bus.ack1_o  = ack1;
  assign bus.err0_o  = err0;
  assign bus.err1_o  = err1;
  assign bus.dat0_o  = rdat0;
  assign bus.dat1_o  = rdat1;
  assign state_test  = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter built with a short timeout so the error
// path is reachable in a few cycles. Expected output snapshots are queued as
// each step is driven and popped for comparison at the following falling edge.
module tb_mem_bus_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_test;

  mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .state_test (state_test)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  st;
    logic        cyc;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        ack0;
    logic        err0;
    logic        ack1;
    logic        err1;
    logic [31:0] d0;
    logic [31:0] d1;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  function automatic obs_t idleExp();
    obs_t e;
    e = '0;
    return e;
  endfunction

  function automatic obs_t gntExp(input logic [1:0] st, input logic we,
                                  input logic [31:0] adr, input logic [31:0] dat);
    obs_t e;
    e     = '0;
    e.st  = st;
    e.cyc = 1'b1;
    e.we  = we;
    e.adr = adr;
    e.dat = dat;
    return e;
  endfunction

  function automatic obs_t sampleDut();
    obs_t o;
    o.st   = state_test;
    o.cyc  = bus.cyc_m2s;
    o.we   = bus.we_m2s;
    o.adr  = bus.adr_m2s;
    o.dat  = bus.dat_m2s;
    o.ack0 = bus.ack0_o;
    o.err0 = bus.err0_o;
    o.ack1 = bus.ack1_o;
    o.err1 = bus.err1_o;
    o.d0   = bus.dat0_o;
    o.d1   = bus.dat1_o;
    return o;
  endfunction

  task automatic applyStimulus(input logic c0, input logic w0, input logic [31:0] a0,
                               input logic [31:0] d0, input logic c1, input logic w1,
                               input logic [31:0] a1, input logic [31:0] d1,
                               input logic am, input logic [31:0] dm);
    bus.cyc0_i    = c0;
    bus.we0_i     = w0;
    bus.adr0_i    = a0;
    bus.dat0_i    = d0;
    bus.cyc1_i    = c1;
    bus.we1_i     = w1;
    bus.adr1_i    = a1;
    bus.dat1_i    = d1;
    bus.ack_mem_i = am;
    bus.dat_mem_i = dm;
  endtask

  // Pop the oldest expectation, compare at the falling edge, then move to
  // just after the next rising edge where new stimulus is driven.
  task automatic checkOutput();
    obs_t  e;
    obs_t  o;
    string t;
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = sampleDut();
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", t, o, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string t, input obs_t e);
    exp_q.push_back(e);
    tag_q.push_back(t);
    checkOutput();
  endtask

  initial begin
    obs_t e;

    // reset held with random inputs: everything must stay quiet
    rst = 1'b0;
    applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom,
                  $urandom_range(0, 1), $urandom);
    step("rst_idle_a", idleExp());
    applyStimulus(1'b1, 1'b1, $urandom, $urandom, 1'b1, 1'b1, $urandom, $urandom,
                  1'b1, $urandom);
    step("rst_idle_b", idleExp());

    // release, then a single read from requester 0 acked in its 3rd cycle
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h100, 32'hA0A0A0A0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step("pre_grant", idleExp());
    step("grant0_c1", gntExp(2'b01, 1'b0, 32'h100, 32'hA0A0A0A0));
    step("read_c2", gntExp(2'b01, 1'b0, 32'h100, 32'hA0A0A0A0));
    bus.ack_mem_i = 1'b1;
    bus.dat_mem_i = 32'hDEADBEEF;
    e      = gntExp(2'b01, 1'b0, 32'h100, 32'hA0A0A0A0);
    e.ack0 = 1'b1;
    e.d0   = 32'hDEADBEEF;
    step("read_ack", e);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step("read_done", idleExp());

    // fresh reset, then contention: requester 0 must win first
    rst = 1'b0;
    step("rst_pulse", idleExp());
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h200, 32'h0BADF00D, 1'b1, 1'b1, 32'h300, 32'h12345678,
                  1'b0, 32'h0);
    step("cont_idle", idleExp());
    bus.ack_mem_i = 1'b1;
    bus.dat_mem_i = 32'h11112222;
    e      = gntExp(2'b01, 1'b0, 32'h200, 32'h0BADF00D);
    e.ack0 = 1'b1;
    e.d0   = 32'h11112222;
    step("cont_gnt0", e);
    bus.ack_mem_i = 1'b0;
    bus.dat_mem_i = 32'h0;
    step("cont_gap", idleExp());

    // requester 1 wins the round robin and then times out in cycle 4
    step("to_c1", gntExp(2'b10, 1'b1, 32'h300, 32'h12345678));
    step("to_c2", gntExp(2'b10, 1'b1, 32'h300, 32'h12345678));
    step("to_c3", gntExp(2'b10, 1'b1, 32'h300, 32'h12345678));
    e      = gntExp(2'b10, 1'b1, 32'h300, 32'h12345678);
    e.err1 = 1'b1;
    step("to_err", e);
    bus.cyc1_i = 1'b0;
    step("to_done", idleExp());

    // abort: requester 0 drops cyc in its 2nd granted cycle
    step("abort_c1", gntExp(2'b01, 1'b0, 32'h200, 32'h0BADF00D));
    bus.cyc0_i = 1'b0;
    e     = gntExp(2'b01, 1'b0, 32'h200, 32'h0BADF00D);
    e.cyc = 1'b0;
    step("abort_c2", e);

    // stray memory ack while idle is ignored
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hCAFEF00D);
    step("stray_ack_a", idleExp());
    step("stray_ack_b", idleExp());

    // ack and timeout in the same cycle: ack wins
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h400, 32'h87654321, 1'b0, 32'h0);
    step("co_idle", idleExp());
    step("co_c1", gntExp(2'b10, 1'b1, 32'h400, 32'h87654321));
    step("co_c2", gntExp(2'b10, 1'b1, 32'h400, 32'h87654321));
    step("co_c3", gntExp(2'b10, 1'b1, 32'h400, 32'h87654321));
    bus.ack_mem_i = 1'b1;
    bus.dat_mem_i = 32'h5A5A5A5A;
    e      = gntExp(2'b10, 1'b1, 32'h400, 32'h87654321);
    e.ack1 = 1'b1;
    e.d1   = 32'h5A5A5A5A;
    step("co_ack", e);
    bus.ack_mem_i = 1'b0;
    bus.dat_mem_i = 32'h0;

    // requester 1 still requesting: new grant, then reset mid-transaction
    step("mid_idle", idleExp());
    step("mid_c1", gntExp(2'b10, 1'b1, 32'h400, 32'h87654321));
    rst        = 1'b0;
    bus.cyc0_i = 1'b1;
    bus.adr0_i = 32'h500;
    bus.dat0_i = 32'h00C0FFEE;
    step("mid_rst", idleExp());

    // after release with both requesting, requester 0 is granted again
    rst = 1'b1;
    step("post_rst_idle", idleExp());
    bus.ack_mem_i = 1'b1;
    bus.dat_mem_i = 32'h77778888;
    e      = gntExp(2'b01, 1'b0, 32'h500, 32'h00C0FFEE);
    e.ack0 = 1'b1;
    e.d0   = 32'h77778888;
    step("post_rst_gnt0", e);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step("final_idle", idleExp());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester round-robin arbiter that shares the single memory-side bus (cyc/we/adr/dat/ack) between the cache controller's miss-fill path (requester 0) and the MSHR write-back path (requester 1). Sits between those requesters and the memory slave. It locks the bus to one requester until ack or timeout, and reports a bus error back to a requester whose transaction times out.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, granted cycles without ack before err; legal range 2..255
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- cyc0_i / cyc1_i  in  1  bus request from requester 0 / 1; held until ack/err
- we0_i / we1_i  in  1  write enable of requester 0 / 1
- adr0_i / adr1_i  in  AW  address of requester 0 / 1
- dat0_i / dat1_i  in  DW  write data of requester 0 / 1
- dat0_o / dat1_o  out  DW  read data to requester 0 / 1
- ack0_o / ack1_o  out  1  transfer complete to requester 0 / 1
- err0_o / err1_o  out  1  timeout error to requester 0 / 1
- cyc_m2s  out  1  bus cycle to memory
- we_m2s  out  1  write enable to memory
- adr_m2s  out  AW  address to memory
- dat_m2s  out  DW  write data to memory
- dat_mem_i  in  DW  read data from memory
- ack_mem_i  in  1  memory acknowledge
- state_test  out  2  current FSM state, debug only

## Operation
- FSM states: IDLE=2'b00, GNT0=2'b01, GNT1=2'b10; 2'b11 unreachable, decodes as IDLE.
- Round-robin pointer `last` (1 bit): requester granted most recently; reset value 1, so requester 0 wins the first contention.
- IDLE: only cyc0_i -> GNT0; only cyc1_i -> GNT1; both -> grant requester != last; none -> stay.
- On entry to GNTx: `last` <= x, timeout counter (8 bits) <= 0.
- GNTx: cyc_m2s=1; we/adr/dat_m2s muxed from requester x. In IDLE all m2s outputs are 0.
- GNTx, ack_mem_i=1: ackx_o=1 and datx_o=dat_mem_i the same cycle (combinational); next state IDLE.
- GNTx, no ack, counter==TIMEOUT-1: errx_o=1 this cycle; next state IDLE. Otherwise counter increments.
- Ack and timeout in the same cycle: ack wins, err stays 0.
- GNTx, cycx_i drops before ack (abort): cyc_m2s drops the same cycle; next state IDLE; no ack/err.
- ack_mem_i in IDLE is ignored; no ack*_o is produced.
- Non-granted requester: ack/err/dat outputs always 0.
- Reset (any time, including mid-transaction): state IDLE, last=1, counter=0; therefore all outputs 0 and state_test=00 while rst=0.

## Timing
- Grant latency: cyc asserted before edge N gives state GNTx after edge N; cyc_m2s is high in cycle N.
- Minimum transaction: 1 granted cycle (ack present in first granted cycle).
- Always at least one IDLE cycle between consecutive grants, so back-to-back requests from the same requester lose one cycle.
- Requester must drop cyc in the cycle after ack/err. If cyc is still high in IDLE, it counts as a new request.
- Timeout: err asserted in the TIMEOUT-th granted cycle; with TIMEOUT=255, in cycle N+254.

## Test plan
- Reset: rst=0 with random inputs -> all outputs 0, state_test=00. Release, then cyc0_i=1 (adr0_i=0x100, we0_i=0) -> cyc_m2s=1, adr_m2s=0x100 one edge later.
- Single read: requester 0; ack_mem_i=1 with dat_mem_i=0xDEADBEEF in the 3rd granted cycle -> ack0_o=1, dat0_o=0xDEADBEEF that cycle; state IDLE next edge; ack1_o=0 throughout.
- Contention after reset: cyc0_i=cyc1_i=1 together -> GNT0 first. After ack, both still requesting -> IDLE one cycle, then GNT1 with we_m2s=we1_i=1 and dat_m2s=dat1_i=0x12345678.
- Timeout with TIMEOUT=4 and no ack -> err1_o=1 in 4th granted cycle. Ack and timeout coinciding -> ack1_o=1, err1_o=0.
- Abort: cyc0_i dropped in 2nd granted cycle -> cyc_m2s=0 same cycle, no ack0_o/err0_o, IDLE next edge. A stray ack_mem_i in IDLE produces no ack*_o.
- Reset mid-transaction: rst=0 during GNT1 -> cyc_m2s=0 immediately (async). After release, simultaneous requests grant requester 0.
